// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

   // Arbiter FSM states; HDR is only reachable when UART_ARB_HEADER_EN is defined.
   typedef enum logic [2:0] {
      ARB,
      HDR,
      LOAD,
      WAIT_BUSY,
      WAIT_DONE
   } uart_arb_state_t;

   // Header bytes carry the granted requester index in the low bits.
   localparam logic [7:0] HDR_BASE = 8'hA0;

   function automatic logic [7:0] hdr_byte(input logic [2:0] id);
      return HDR_BASE | {5'b00000, id};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first asserted request after the last grant,
// wrapping around, and reports it both one-hot and as an index.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last,
   output logic [NUM_REQ-1:0]         gnt_oh,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
   output logic                       any
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   logic          found;
   logic [IW-1:0] cand;

   // Scan last+1 .. last+NUM_REQ so the previous winner has the lowest priority.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      any     = |req;
      found   = 1'b0;
      cand    = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = IW'((32'(last) + i) % NUM_REQ);
         if (!found && req[cand]) begin
            found        = 1'b1;
            gnt_idx      = cand;
            gnt_oh[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uartTX transmitter between NUM_REQ byte-stream requesters.
// Round-robin grant per burst, bursts capped at MAX_BURST bytes, and a
// watchdog on the tx_start -> tx_busy handshake.
// Optional: define UART_ARB_HEADER_EN to prefix every burst with a header
// byte HDR_BASE | grant_id.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned MAX_BURST    = 16,
   parameter int unsigned BUSY_TIMEOUT = 15
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*8-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [7:0]                 tx_data,
   output logic                       tx_start,
   input  logic                       tx_busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       grant_act,
   output logic                       err_timeout
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned BW = $clog2(MAX_BURST + 1);
   localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

   uart_arb_state_t    state_q, state_d;
   logic [IW-1:0]      grant_id_q, grant_id_d;
   logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
   logic               grant_act_q, grant_act_d;
   logic [BW-1:0]      burst_cnt_q, burst_cnt_d;
   logic               last_q, last_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic               hdr_q, hdr_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_start_q, tx_start_d;
   logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
   logic               err_q, err_d;

   logic [NUM_REQ-1:0] arb_oh;
   logic [IW-1:0]      arb_idx;
   logic               arb_any;

   logic               gnt_valid;
   logic               gnt_last;
   logic [7:0]         gnt_byte;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req     (req_valid),
      .last    (grant_id_q),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   // Next-state and output decode; all outputs are registered so tx_start,
   // req_ready and tx_data change together one cycle after LOAD.
   always_comb begin
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      grant_oh_d  = grant_oh_q;
      grant_act_d = grant_act_q;
      burst_cnt_d = burst_cnt_q;
      last_d      = last_q;
      timer_d     = timer_q;
      hdr_d       = hdr_q;
      tx_data_d   = tx_data_q;
      tx_start_d  = 1'b0;
      req_ready_d = '0;
      err_d       = 1'b0;

      gnt_valid = |(req_valid & grant_oh_q);
      gnt_last  = |(req_last & grant_oh_q);
      gnt_byte  = req_data[8*grant_id_q +: 8];

      unique case (state_q)
         ARB: begin
            if (arb_any) begin
               grant_id_d  = arb_idx;
               grant_oh_d  = arb_oh;
               grant_act_d = 1'b1;
               burst_cnt_d = '0;
`ifdef UART_ARB_HEADER_EN
               state_d     = HDR;
`else
               state_d     = LOAD;
`endif
            end
         end
`ifdef UART_ARB_HEADER_EN
         HDR: begin
            // Header is not handshaked with the requester and not counted.
            tx_data_d  = hdr_byte(3'(grant_id_q));
            tx_start_d = 1'b1;
            hdr_d      = 1'b1;
            timer_d    = '0;
            state_d    = WAIT_BUSY;
         end
`endif
         LOAD: begin
            if (gnt_valid) begin
               tx_data_d   = gnt_byte;
               req_ready_d = grant_oh_q;
               tx_start_d  = 1'b1;
               last_d      = gnt_last;
               burst_cnt_d = burst_cnt_q + BW'(1);
               timer_d     = '0;
               state_d     = WAIT_BUSY;
            end else begin
               grant_act_d = 1'b0;
               state_d     = ARB;
            end
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
               // Transmitter never acknowledged: drop the byte and re-arbitrate.
               err_d       = 1'b1;
               grant_act_d = 1'b0;
               hdr_d       = 1'b0;
               state_d     = ARB;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               if (hdr_q) begin
                  hdr_d   = 1'b0;
                  state_d = LOAD;
               end else if (last_q || (burst_cnt_q == BW'(MAX_BURST))) begin
                  grant_act_d = 1'b0;
                  state_d     = ARB;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         default: state_d = ARB;
      endcase
   end

   // State and output registers; async reset parks the pointer so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB;
         grant_id_q  <= IW'(NUM_REQ - 1);
         grant_oh_q  <= '0;
         grant_act_q <= 1'b0;
         burst_cnt_q <= '0;
         last_q      <= 1'b0;
         timer_q     <= '0;
         hdr_q       <= 1'b0;
         tx_data_q   <= 8'h00;
         tx_start_q  <= 1'b0;
         req_ready_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_id_q  <= grant_id_d;
         grant_oh_q  <= grant_oh_d;
         grant_act_q <= grant_act_d;
         burst_cnt_q <= burst_cnt_d;
         last_q      <= last_d;
         timer_q     <= timer_d;
         hdr_q       <= hdr_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         req_ready_q <= req_ready_d;
         err_q       <= err_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign grant_id    = grant_id_q;
   assign grant_act   = grant_act_q;
   assign err_timeout = err_q;

endmodule
